i2c_slave_fsm: RTL
==================

Name: i2c_slave_fsm

Overview:
- I2C target (slave) FSM; the other end of the bus from `fsm_master`.
- Oversamples SCL/SDA on the system clock and detects START/STOP.
- Matches a 7-bit own address and ACKs it, then either receives write bytes or transmits read bytes.
- Drives SDA open-drain; never drives SCL. Used as the bus responder in master bring-up and as a reusable peripheral front end.

Parameters:
- ADDR_LEN, 7, address width in bits.
- DATA_LEN, 8, data byte width.
- OWN_ADDR, 7'b1010110, address this target responds to.
- FREQ_DIFF, 4, minimum clk cycles per SCL half-period; design requirement, not used in logic.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- scl  input  1  bus clock from master.
- sda  inout  1  bus data; driven 0 or released to Z only.
- tx_data  input  DATA_LEN  byte to return on read; sampled when tx_req pulses.
- rx_data  output  DATA_LEN  last byte received on write.
- rx_valid  output  1  one-clk pulse, rx_data updated.
- tx_req  output  1  one-clk pulse, tx_data latched into shifter.
- state_slave  output  4  current FSM state.
- busy  output  1  high from START to STOP.

Behaviour:
- Reset: state IDLE (4'd0), sda released (Z), rx_data=0, rx_valid=0, tx_req=0, busy=0; synchronizers preset to 1. Reset mid-transfer aborts immediately and releases SDA.
- Input conditioning: 2-flop synchronizers on scl/sda, plus one delayed copy of each for edge detection.
  - scl_rise/scl_fall are single-cycle pulses.
  - START = synced SDA 1->0 while synced SCL=1.
  - STOP = synced SDA 0->1 while synced SCL=1.
- Bit timing: sample SDA on scl_rise; change the driven SDA on scl_fall only.
- State encoding:
  - IDLE=0, ADDR=1, ADDR_ACK=2, RX=3, RX_ACK=4, TX=5, TX_ACK=6, WAIT_STOP=7.
  - busy = (state != IDLE).
- Transitions:
  - IDLE: START -> ADDR, bit count=0.
  - ADDR: shift 8 bits (7 address MSB-first, then R/W).
    - After the 8th scl_fall: match -> ADDR_ACK with SDA driven 0.
    - Mismatch -> WAIT_STOP with SDA released.
  - ADDR_ACK:
    - Hold SDA low through the 9th SCL high.
    - On the 9th scl_fall: R/W=0 -> RX with SDA released.
    - R/W=1 -> TX: tx_req pulses that cycle, tx_data is latched, and its MSB is driven.
  - RX:
    - After the 8th scl_rise, rx_data updates and rx_valid pulses one clk later.
    - On the 8th scl_fall -> RX_ACK and drive SDA 0.
  - RX_ACK: on the 9th scl_fall, release SDA -> RX (next byte).
  - TX:
    - Drive shifter MSB-first; a bit value of 1 means released.
    - After the 8th scl_fall, release SDA -> TX_ACK.
  - TX_ACK: sample the master ACK on scl_rise, then act on scl_fall:
    - ACK (0): tx_req pulses, next byte latched, -> TX.
    - NACK (1): -> WAIT_STOP, SDA released.
  - WAIT_STOP: ignore the bus until STOP/START.
- Precedence:
  - STOP in any state -> IDLE, SDA released.
  - START in any non-IDLE state (repeated start) -> ADDR, SDA released, bit count cleared.
  - START/STOP take priority over the scl edges in the same cycle.
- SDA is never driven 1. The sda output is 0 when driving low, else Z.

Optional Feature:
- Macro: I2C_SLAVE_GENCALL_EN.
- Defined: address 7'b0000000 with R/W=0 is also ACKed and proceeds to RX exactly like an own-address write. General call with R/W=1 -> WAIT_STOP, no ACK.
- Not defined: address 0 is treated as a mismatch -> WAIT_STOP, no ACK.

Test Plan:
- Write, address 7'b1010110 + W: master sends START, byte 0xAC, byte 0xAB, STOP. Required: SDA=0 in both 9th-clock windows; rx_data=8'hAB with one rx_valid pulse; state 0->1->2->3->4->3->0.
- Read, address 7'b1010110 + R, tx_data=8'hAB: required tx_req pulse; SDA on SCL highs reads 1,0,1,0,1,0,1,1. Master ACK -> second tx_req pulse; master NACK -> SDA released, state 7; STOP -> state 0, busy=0.
- Address mismatch 7'h2A: SDA stays Z through the ACK clock, state=7, no rx_valid/tx_req; STOP -> IDLE.
- Repeated START after the write address ACK, then 7'b1010110 + R: state returns to 1 with SDA released, then the read proceeds normally.
- rst_n=0 asserted after the 4th data bit of RX with SDA low: sda immediately Z, state=0, rx_data=0, busy=0.
- Address 0 + W: ACKed with rx_valid if I2C_SLAVE_GENCALL_EN is defined; NACK and state 7 otherwise.

Source files
------------

// File: rtl/i2c_slave_fsm.sv
// I2C target FSM: oversampled SCL/SDA, START/STOP detection, 7-bit address match, open-drain SDA.
// Optional: define I2C_SLAVE_GENCALL_EN to also ACK general-call (address 0) writes.
module i2c_slave_fsm #(
  parameter int                  ADDR_LEN  = 7,
  parameter int                  DATA_LEN  = 8,
  parameter logic [ADDR_LEN-1:0] OWN_ADDR  = 7'b1010110,
  parameter int                  FREQ_DIFF = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                scl,
  inout  wire                 sda,
  input  logic [DATA_LEN-1:0] tx_data,
  output logic [DATA_LEN-1:0] rx_data,
  output logic                rx_valid,
  output logic                tx_req,
  output logic [3:0]          state_slave,
  output logic                busy
);

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_ADDR      = 4'd1;
  localparam logic [3:0] S_ADDR_ACK  = 4'd2;
  localparam logic [3:0] S_RX        = 4'd3;
  localparam logic [3:0] S_RX_ACK    = 4'd4;
  localparam logic [3:0] S_TX        = 4'd5;
  localparam logic [3:0] S_TX_ACK    = 4'd6;
  localparam logic [3:0] S_WAIT_STOP = 4'd7;

  localparam int CNT_W = $clog2(((ADDR_LEN + 1) > DATA_LEN ? (ADDR_LEN + 1) : DATA_LEN) + 2);
  localparam logic [CNT_W-1:0] ADDR_BITS = CNT_W'(ADDR_LEN + 1);
  localparam logic [CNT_W-1:0] DATA_BITS = CNT_W'(DATA_LEN);

  // [0],[1] form the synchronizer; [2] is the delayed copy used for edge detection
  logic [2:0] scl_pipe_reg;
  logic [2:0] sda_pipe_reg;

  logic [3:0]          state_reg;
  logic [CNT_W-1:0]    bit_cnt_reg;
  logic [ADDR_LEN:0]   addr_shift_reg;
  logic [DATA_LEN-2:0] rx_shift_reg;
  logic [DATA_LEN-2:0] tx_shift_reg;
  logic                rw_reg;
  logic                ack_reg;
  logic                sda_low_reg;

  logic scl_sync, scl_dly, sda_sync, sda_dly;
  logic scl_rise, scl_fall, start_det, stop_det;
  logic [ADDR_LEN-1:0] addr_field;
  logic                rw_field;
  logic                addr_match;
  logic                unused_freq_diff;

  assign scl_sync  = scl_pipe_reg[1];
  assign scl_dly   = scl_pipe_reg[2];
  assign sda_sync  = sda_pipe_reg[1];
  assign sda_dly   = sda_pipe_reg[2];
  assign scl_rise  = scl_sync & ~scl_dly;
  assign scl_fall  = ~scl_sync & scl_dly;
  assign start_det = scl_sync & sda_dly & ~sda_sync;
  assign stop_det  = scl_sync & ~sda_dly & sda_sync;

  assign addr_field = addr_shift_reg[ADDR_LEN:1];
  assign rw_field   = addr_shift_reg[0];

`ifdef I2C_SLAVE_GENCALL_EN
  assign addr_match = (addr_field == OWN_ADDR) || ((addr_field == '0) && !rw_field);
`else
  assign addr_match = (addr_field == OWN_ADDR);
`endif

  // Minimum oversampling ratio is a system-level constraint only
  assign unused_freq_diff = (FREQ_DIFF > 0);

  assign sda         = sda_low_reg ? 1'b0 : 1'bz;
  assign state_slave = state_reg;
  assign busy        = (state_reg != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_pipe_reg <= 3'b111;
      sda_pipe_reg <= 3'b111;
    end else begin
      scl_pipe_reg <= {scl_pipe_reg[1:0], scl};
      sda_pipe_reg <= {sda_pipe_reg[1:0], sda};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= S_IDLE;
      bit_cnt_reg    <= '0;
      addr_shift_reg <= '0;
      rx_shift_reg   <= '0;
      tx_shift_reg   <= '0;
      rw_reg         <= 1'b0;
      ack_reg        <= 1'b1;
      sda_low_reg    <= 1'b0;
      rx_data        <= '0;
      rx_valid       <= 1'b0;
      tx_req         <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      tx_req   <= 1'b0;
      // Bus conditions outrank any SCL edge seen in the same cycle
      if (stop_det) begin
        state_reg   <= S_IDLE;
        sda_low_reg <= 1'b0;
      end else if (start_det) begin
        state_reg   <= S_ADDR;
        sda_low_reg <= 1'b0;
        bit_cnt_reg <= '0;
      end else begin
        case (state_reg)
          S_ADDR: begin
            if (scl_rise) begin
              addr_shift_reg <= {addr_shift_reg[ADDR_LEN-1:0], sda_sync};
              bit_cnt_reg    <= bit_cnt_reg + 1'b1;
            end else if (scl_fall && (bit_cnt_reg == ADDR_BITS)) begin
              rw_reg <= rw_field;
              if (addr_match) begin
                state_reg   <= S_ADDR_ACK;
                sda_low_reg <= 1'b1;
              end else begin
                state_reg   <= S_WAIT_STOP;
                sda_low_reg <= 1'b0;
              end
            end
          end
          S_ADDR_ACK: begin
            if (scl_fall) begin
              bit_cnt_reg <= '0;
              if (rw_reg) begin
                state_reg    <= S_TX;
                tx_req       <= 1'b1;
                tx_shift_reg <= tx_data[DATA_LEN-2:0];
                sda_low_reg  <= ~tx_data[DATA_LEN-1];
              end else begin
                state_reg   <= S_RX;
                sda_low_reg <= 1'b0;
              end
            end
          end
          S_RX: begin
            if (scl_rise) begin
              rx_shift_reg <= {rx_shift_reg[DATA_LEN-3:0], sda_sync};
              bit_cnt_reg  <= bit_cnt_reg + 1'b1;
              if (bit_cnt_reg == DATA_BITS - 1'b1) begin
                rx_data  <= {rx_shift_reg, sda_sync};
                rx_valid <= 1'b1;
              end
            end else if (scl_fall && (bit_cnt_reg == DATA_BITS)) begin
              state_reg   <= S_RX_ACK;
              sda_low_reg <= 1'b1;
            end
          end
          S_RX_ACK: begin
            if (scl_fall) begin
              state_reg   <= S_RX;
              sda_low_reg <= 1'b0;
              bit_cnt_reg <= '0;
            end
          end
          S_TX: begin
            if (scl_rise) begin
              bit_cnt_reg <= bit_cnt_reg + 1'b1;
            end else if (scl_fall) begin
              if (bit_cnt_reg == DATA_BITS) begin
                state_reg   <= S_TX_ACK;
                sda_low_reg <= 1'b0;
              end else begin
                // A 1 bit is sent by releasing the line
                sda_low_reg  <= ~tx_shift_reg[DATA_LEN-2];
                tx_shift_reg <= {tx_shift_reg[DATA_LEN-3:0], 1'b0};
              end
            end
          end
          S_TX_ACK: begin
            if (scl_rise) begin
              ack_reg <= sda_sync;
            end else if (scl_fall) begin
              if (!ack_reg) begin
                state_reg    <= S_TX;
                tx_req       <= 1'b1;
                tx_shift_reg <= tx_data[DATA_LEN-2:0];
                sda_low_reg  <= ~tx_data[DATA_LEN-1];
                bit_cnt_reg  <= '0;
              end else begin
                state_reg   <= S_WAIT_STOP;
                sda_low_reg <= 1'b0;
              end
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule
